// File: rtl/tamagotchi_core.sv
`default_nettype none
// ==========================================================================
// tamagotchi_core : virtual-pet levels, decay timers, health flags, status
// Revision 1.0
// ==========================================================================
module tamagotchi_core #(
  parameter int unsigned TICK_CYCLES      = 50000000,
  parameter int unsigned TEST_TICK_CYCLES = 5000000,
  parameter int unsigned H_PERIOD         = 30,
  parameter int unsigned D_PERIOD         = 20,
  parameter int unsigned E_PERIOD         = 40,
  parameter int unsigned ILL_TICKS        = 10,
  parameter int unsigned DEATH_TICKS      = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alimentar,
  input  logic       jugar,
  input  logic       test,
  input  logic       luz,
  input  logic       calor,
  input  logic       frio,
  output logic [2:0] stat,
  output logic [2:0] h,
  output logic [2:0] e,
  output logic [2:0] d,
  output logic       tmode
);

  localparam int unsigned c_tick_max = (TICK_CYCLES > TEST_TICK_CYCLES) ? TICK_CYCLES : TEST_TICK_CYCLES;
  localparam int c_tw = $clog2(c_tick_max + 1);
  localparam int c_hw = $clog2(H_PERIOD + 1);
  localparam int c_dw = $clog2(D_PERIOD + 1);
  localparam int c_ew = $clog2(E_PERIOD + 1);
  localparam int c_iw = $clog2(ILL_TICKS + 1);
  localparam int c_sw = $clog2(DEATH_TICKS + 1);

  localparam logic [c_tw-1:0] c_norm_last = c_tw'(TICK_CYCLES - 1);
  localparam logic [c_tw-1:0] c_test_last = c_tw'(TEST_TICK_CYCLES - 1);
  localparam logic [c_hw-1:0] c_h_last    = c_hw'(H_PERIOD - 1);
  localparam logic [c_dw-1:0] c_d_last    = c_dw'(D_PERIOD - 1);
  localparam logic [c_ew-1:0] c_e_last    = c_ew'(E_PERIOD - 1);
  localparam logic [c_iw-1:0] c_ill_max   = c_iw'(ILL_TICKS);
  localparam logic [c_sw-1:0] c_death_max = c_sw'(DEATH_TICKS);

  // Synchronizer bit order {frio, calor, luz, test, jugar, alimentar}; buttons idle high
  localparam logic [5:0] c_sync_rst = 6'b000111;

  localparam logic [2:0] c_st_happy  = 3'd0;
  localparam logic [2:0] c_st_bored  = 3'd1;
  localparam logic [2:0] c_st_tired  = 3'd2;
  localparam logic [2:0] c_st_sleep  = 3'd3;
  localparam logic [2:0] c_st_hungry = 3'd4;
  localparam logic [2:0] c_st_sick   = 3'd5;
  localparam logic [2:0] c_st_dead   = 3'd6;
  localparam logic [2:0] c_lvl_max   = 3'd5;

  logic [5:0]      s1_q, s2_q;
  logic [2:0]      btn_prev_q;
  logic [c_tw-1:0] tick_cnt_q, tick_cnt_d;
  logic [c_hw-1:0] h_cnt_q, h_cnt_d;
  logic [c_dw-1:0] d_cnt_q, d_cnt_d;
  logic [c_ew-1:0] e_cnt_q, e_cnt_d;
  logic [c_iw-1:0] abn_q, abn_d;
  logic [c_sw-1:0] starve_q, starve_d;
  logic [2:0]      h_q, h_d, e_q, e_d, d_q, d_d, stat_q, stat_d;
  logic            tmode_q, tmode_d, sick_q, sick_d, dead_q, dead_d;

  logic [2:0] press;
  logic       sleeping, abnormal, tick, h_step, d_step, e_step, feed_ok, play_ok;

  // Level update: one optional increment and up to two decrements, clamped to 0..5
  function automatic logic [2:0] step_level(input logic [2:0] lvl, input logic up,
                                            input logic [1:0] down);
    logic signed [4:0] t;
    t = $signed({2'b00, lvl}) + $signed({4'b0000, up}) - $signed({3'b000, down});
    if (t < 5'sd0)      step_level = 3'd0;
    else if (t > 5'sd5) step_level = c_lvl_max;
    else                step_level = t[2:0];
  endfunction

  assign press    = btn_prev_q & ~s2_q[2:0];
  assign sleeping = s2_q[3];
  assign abnormal = s2_q[4] ^ s2_q[5];
  assign tick     = (tick_cnt_q == (tmode_q ? c_test_last : c_norm_last));
  assign h_step   = tick && (h_cnt_q == c_h_last);
  assign d_step   = tick && (d_cnt_q == c_d_last);
  assign e_step   = tick && (e_cnt_q == c_e_last);
  assign feed_ok  = press[0] && !sleeping && !dead_q;
  assign play_ok  = press[1] && !sleeping && !dead_q && (e_q != 3'd0);

  always_comb begin
    tmode_d    = tmode_q ^ press[2];
    tick_cnt_d = (press[2] || tick) ? '0 : tick_cnt_q + 1'b1;

    h_cnt_d = h_cnt_q;
    d_cnt_d = d_cnt_q;
    e_cnt_d = e_cnt_q;
    if (tick) begin
      h_cnt_d = h_step ? '0 : h_cnt_q + 1'b1;
      d_cnt_d = d_step ? '0 : d_cnt_q + 1'b1;
      e_cnt_d = e_step ? '0 : e_cnt_q + 1'b1;
    end

    abn_d  = abn_q;
    sick_d = sick_q;
    if (tick) begin
      if (abnormal) begin
        if (abn_q != c_ill_max) abn_d = abn_q + 1'b1;
        if (abn_d == c_ill_max) sick_d = 1'b1;
      end else begin
        abn_d  = '0;
        sick_d = 1'b0;
      end
    end

    starve_d = starve_q;
    if (h_q != 3'd0)                        starve_d = '0;
    else if (tick && starve_q != c_death_max) starve_d = starve_q + 1'b1;
    dead_d = dead_q || (starve_d == c_death_max);

    h_d = h_q;
    d_d = d_q;
    e_d = e_q;
    if (!dead_q) begin
      h_d = step_level(h_q, feed_ok, {1'b0, h_step});
      d_d = step_level(d_q, play_ok, {1'b0, d_step});
      e_d = step_level(e_q, e_step && sleeping,
                       {1'b0, play_ok} + {1'b0, e_step && !sleeping});
    end

    if (dead_q)            stat_d = c_st_dead;
    else if (sleeping)     stat_d = c_st_sleep;
    else if (sick_q)       stat_d = c_st_sick;
    else if (h_q <= 3'd1)  stat_d = c_st_hungry;
    else if (e_q <= 3'd1)  stat_d = c_st_tired;
    else if (d_q <= 3'd1)  stat_d = c_st_bored;
    else                   stat_d = c_st_happy;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q       <= c_sync_rst;
      s2_q       <= c_sync_rst;
      btn_prev_q <= 3'b111;
      tick_cnt_q <= '0;
      h_cnt_q    <= '0;
      d_cnt_q    <= '0;
      e_cnt_q    <= '0;
      abn_q      <= '0;
      starve_q   <= '0;
      h_q        <= c_lvl_max;
      e_q        <= c_lvl_max;
      d_q        <= c_lvl_max;
      stat_q     <= c_st_happy;
      tmode_q    <= 1'b0;
      sick_q     <= 1'b0;
      dead_q     <= 1'b0;
    end else begin
      s1_q       <= {frio, calor, luz, test, jugar, alimentar};
      s2_q       <= s1_q;
      btn_prev_q <= s2_q[2:0];
      tick_cnt_q <= tick_cnt_d;
      h_cnt_q    <= h_cnt_d;
      d_cnt_q    <= d_cnt_d;
      e_cnt_q    <= e_cnt_d;
      abn_q      <= abn_d;
      starve_q   <= starve_d;
      h_q        <= h_d;
      e_q        <= e_d;
      d_q        <= d_d;
      stat_q     <= stat_d;
      tmode_q    <= tmode_d;
      sick_q     <= sick_d;
      dead_q     <= dead_d;
    end
  end

  assign stat  = stat_q;
  assign h     = h_q;
  assign e     = e_q;
  assign d     = d_q;
  assign tmode = tmode_q;

endmodule
`default_nettype wire

// File: tb/tb_tamagotchi_core.sv
`default_nettype none
// ==========================================================================
// tb_tamagotchi_core : random + directed stimulus, reference model, scoreboard
// Revision 1.0
// ==========================================================================
module tb_tamagotchi_core;

  localparam int TICK   = 10;
  localparam int TEST_T = 2;
  localparam int HP     = 2;
  localparam int DP     = 3;
  localparam int EP     = 4;
  localparam int ILL    = 3;
  localparam int DEATH  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic alimentar = 1'b1, jugar = 1'b1, test = 1'b1;
  logic luz = 1'b0, calor = 1'b0, frio = 1'b0;
  logic [2:0] stat, h, e, d;
  logic       tmode;

  tamagotchi_core #(
    .TICK_CYCLES(TICK), .TEST_TICK_CYCLES(TEST_T), .H_PERIOD(HP), .D_PERIOD(DP),
    .E_PERIOD(EP), .ILL_TICKS(ILL), .DEATH_TICKS(DEATH)
  ) dut (
    .clk(clk), .reset(reset), .alimentar(alimentar), .jugar(jugar), .test(test),
    .luz(luz), .calor(calor), .frio(frio),
    .stat(stat), .h(h), .e(e), .d(d), .tmode(tmode)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] stat;
    logic [2:0] h;
    logic [2:0] e;
    logic [2:0] d;
    logic       tmode;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: pet state in plain integers
  int m_h, m_e, m_d, m_stat, m_cnt, m_hc, m_dc, m_ec, m_abn, m_starve;
  bit m_tmode, m_sick, m_dead;
  logic [5:0] smp1, smp2, smp3;  // raw input samples taken 1, 2 and 3 edges ago

  function automatic int clamp5(input int v);
    if (v < 0) return 0;
    if (v > 5) return 5;
    return v;
  endfunction

  task automatic model_reset();
    m_h = 5; m_e = 5; m_d = 5; m_stat = 0;
    m_cnt = 0; m_hc = 0; m_dc = 0; m_ec = 0; m_abn = 0; m_starve = 0;
    m_tmode = 0; m_sick = 0; m_dead = 0;
    smp1 = 6'b000111; smp2 = 6'b000111; smp3 = 6'b000111;
  endtask

  task automatic model_step(input logic [5:0] x);
    bit feed, play, tp, sl, ab, tick, hs, ds, es, was_dead, fa, pa;
    int n;
    sl   = smp2[3];
    ab   = smp2[4] ^ smp2[5];
    feed = smp3[0] & ~smp2[0];
    play = smp3[1] & ~smp2[1];
    tp   = smp3[2] & ~smp2[2];
    was_dead = m_dead;

    if (m_dead)        m_stat = 6;
    else if (sl)       m_stat = 3;
    else if (m_sick)   m_stat = 5;
    else if (m_h <= 1) m_stat = 4;
    else if (m_e <= 1) m_stat = 2;
    else if (m_d <= 1) m_stat = 1;
    else               m_stat = 0;

    n     = m_tmode ? TEST_T : TICK;
    tick  = (m_cnt == n - 1);
    m_cnt = (tp || tick) ? 0 : m_cnt + 1;
    if (tp) m_tmode = !m_tmode;

    hs = 0; ds = 0; es = 0;
    if (tick) begin
      hs = (m_hc == HP - 1); m_hc = hs ? 0 : m_hc + 1;
      ds = (m_dc == DP - 1); m_dc = ds ? 0 : m_dc + 1;
      es = (m_ec == EP - 1); m_ec = es ? 0 : m_ec + 1;
      if (ab) begin
        if (m_abn < ILL) m_abn++;
        if (m_abn >= ILL) m_sick = 1;
      end else begin
        m_abn = 0; m_sick = 0;
      end
    end

    if (m_h > 0)                        m_starve = 0;
    else if (tick && m_starve < DEATH) m_starve++;
    if (m_starve >= DEATH) m_dead = 1;

    if (!was_dead) begin
      fa  = feed && !sl;
      pa  = play && !sl && (m_e > 0);
      m_h = clamp5(m_h + int'(fa) - int'(hs));
      m_d = clamp5(m_d + int'(pa) - int'(ds));
      m_e = clamp5(m_e - int'(pa) + (es ? (sl ? 1 : -1) : 0));
    end

    smp3 = smp2; smp2 = smp1; smp1 = x;
  endtask

  // Producer: advance the model every edge and queue what the DUT must show
  initial begin
    obs_t o;
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      if (reset) model_reset();
      else       model_step({frio, calor, luz, test, jugar, alimentar});
      o.stat  = m_stat[2:0];
      o.h     = m_h[2:0];
      o.e     = m_e[2:0];
      o.d     = m_d[2:0];
      o.tmode = m_tmode;
      exp_q.push_back(o);
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  // Monitor: outputs are valid every cycle, compare against the queue head
  initial begin
    obs_t o;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
      end else begin
        o = exp_q.pop_front();
        chk("stat",  int'(stat),  int'(o.stat));
        chk("h",     int'(h),     int'(o.h));
        chk("e",     int'(e),     int'(o.e));
        chk("d",     int'(d),     int'(o.d));
        chk("tmode", int'(tmode), int'(o.tmode));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    alimentar = 1'b1; jugar = 1'b1; test = 1'b1;
    luz = 1'b0; calor = 1'b0; frio = 1'b0;
    cyc(2);
    reset = 1'b0;
  endtask

  // 0 feed, 1 play, 2 test: hold low 4 cycles then release for 4
  task automatic press(input int which);
    case (which)
      0: alimentar = 1'b0;
      1: jugar = 1'b0;
      default: test = 1'b0;
    endcase
    cyc(4);
    alimentar = 1'b1; jugar = 1'b1; test = 1'b1;
    cyc(4);
  endtask

  initial begin
    cyc(2);
    reset = 1'b0;
    cyc(25);

    // Feed press landing on hunger steps at full and empty levels, then death
    do_reset();
    cyc(17);
    alimentar = 1'b0; cyc(4); alimentar = 1'b1;
    cyc(96);
    alimentar = 1'b0; cyc(4); alimentar = 1'b1;
    cyc(30);
    press(0); press(0); press(1);
    press(2); cyc(12); press(2);
    do_reset();
    cyc(5);

    // Drain energy by playing, then play with no energy
    for (int i = 0; i < 7; i++) press(1);
    press(0); press(0);

    // Temperature sickness, recovery, then sleep overriding sickness
    do_reset();
    calor = 1'b1; cyc(40);
    frio = 1'b1;  cyc(15);
    frio = 1'b0;  cyc(40);
    luz = 1'b1;   cyc(60);
    press(0);
    luz = 1'b0;   cyc(10);

    // Test mode period switching
    do_reset();
    cyc(3);
    press(2); cyc(20);
    press(2); cyc(30);

    // Randomized operation with occasional mid-run resets
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 9) == 0)   alimentar = ~alimentar;
      if ($urandom_range(0, 11) == 0)  jugar = ~jugar;
      if ($urandom_range(0, 59) == 0)  test = ~test;
      if ($urandom_range(0, 149) == 0) luz = ~luz;
      if ($urandom_range(0, 99) == 0)  calor = ~calor;
      if ($urandom_range(0, 99) == 0)  frio = ~frio;
    end
    reset = 1'b0;
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
